// File: rtl/exe_muldiv_seq_pkg.sv
// Shared definitions for the sequential RV M-extension execute unit:
// funct3 op codes, FSM state encoding and operand-signedness helpers.
package exe_muldiv_seq_pkg;

    localparam logic [2:0] MUL_F3    = 3'b000;
    localparam logic [2:0] MULH_F3   = 3'b001;
    localparam logic [2:0] MULHSU_F3 = 3'b010;
    localparam logic [2:0] MULHU_F3  = 3'b011;
    localparam logic [2:0] DIV_F3    = 3'b100;
    localparam logic [2:0] DIVU_F3   = 3'b101;
    localparam logic [2:0] REM_F3    = 3'b110;
    localparam logic [2:0] REMU_F3   = 3'b111;

    // Writeback source codes shared with the single-cycle execute stage.
    localparam logic [1:0] ZERO = 2'b00;
    localparam logic [1:0] MEM  = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    function automatic logic op1_signed(input logic [2:0] f3);
        return (f3 == MULH_F3) || (f3 == MULHSU_F3) || (f3 == DIV_F3) || (f3 == REM_F3);
    endfunction

    function automatic logic op2_signed(input logic [2:0] f3);
        return (f3 == MULH_F3) || (f3 == DIV_F3) || (f3 == REM_F3);
    endfunction

endpackage

// File: rtl/exe_muldiv_seq_divcore.sv
// Restoring-division datapath, one quotient bit per cycle on unsigned magnitudes.
// Also owns the iteration counter that the parent uses to end multiplies.
module muldiv_divcore
    import exe_muldiv_seq_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic            step_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic            last_o,
    output logic [XLEN-1:0] quo_next_o,
    output logic [XLEN-1:0] rem_next_o
);

    localparam int CW = (XLEN > 1) ? $clog2(XLEN) : 1;

    logic [CW-1:0]   cnt_r;
    logic [XLEN:0]   rem_r;
    logic [XLEN:0]   rem_nxt_s;
    logic [XLEN-1:0] quo_r;
    logic [XLEN-1:0] dsr_r;
    logic [XLEN-1:0] quo_nxt_s;
    logic [XLEN+1:0] trial_s;

    // One restoring step: shift in the next dividend bit and try to subtract.
    always_comb begin
        trial_s = {rem_r, quo_r[XLEN-1]} - {2'b00, dsr_r};
        if (trial_s[XLEN+1]) begin
            rem_nxt_s = {rem_r[XLEN-1:0], quo_r[XLEN-1]};
        end else begin
            rem_nxt_s = trial_s[XLEN:0];
        end
        quo_nxt_s = {quo_r[XLEN-2:0], ~trial_s[XLEN+1]};
    end

    // Counter, partial remainder and dividend/quotient shift register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_r <= '0;
            rem_r <= '0;
            quo_r <= '0;
            dsr_r <= '0;
        end else if (start_i) begin
            cnt_r <= CW'(XLEN - 1);
            rem_r <= '0;
            quo_r <= dividend_i;
            dsr_r <= divisor_i;
        end else if (step_i) begin
            cnt_r <= cnt_r - CW'(1);
            rem_r <= rem_nxt_s;
            quo_r <= quo_nxt_s;
        end
    end

    assign last_o     = (cnt_r == '0);
    assign quo_next_o = quo_nxt_s;
    assign rem_next_o = rem_nxt_s[XLEN-1:0];

endmodule

// File: rtl/exe_muldiv_seq.sv
// Multi-cycle RV M-extension unit: shift-add multiply, restoring divide, fast paths.
// Define MULDIV_FAST_MUL_EN for single-cycle multiplies; divide stays iterative.
module exe_muldiv_seq
    import exe_muldiv_seq_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int RADDR_WIDTH = 5
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   valid_i,
    output logic                   ready_o,
    input  logic [2:0]             funct3_i,
    input  logic [XLEN-1:0]        op1_i,
    input  logic [XLEN-1:0]        op2_i,
    input  logic [RADDR_WIDTH-1:0] reg_waddr_i,
    input  logic                   flush_i,
    output logic                   valid_o,
    input  logic                   out_ready_i,
    output logic [XLEN-1:0]        result_o,
    output logic [RADDR_WIDTH-1:0] reg_waddr_o,
    output logic                   reg_we_o,
    output logic                   busy_o
);

    localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

    state_e                 state_r;
    state_e                 state_nxt_s;
    logic [2:0]             f3_r;
    logic                   neg_r;
    logic                   rem_neg_r;
    logic [XLEN-1:0]        mcand_r;
    logic [XLEN-1:0]        result_r;
    logic [2*XLEN-1:0]      acc_r;
    logic [RADDR_WIDTH-1:0] waddr_r;

    logic                   s1_s;
    logic                   s2_s;
    logic                   fast_s;
    logic                   accept_s;
    logic                   div_last_s;
    logic [XLEN-1:0]        mag1_s;
    logic [XLEN-1:0]        mag2_s;
    logic [XLEN-1:0]        fast_res_s;
    logic [XLEN-1:0]        calc_res_s;
    logic [XLEN-1:0]        quo_nxt_s;
    logic [XLEN-1:0]        rem_nxt_s;
    logic [XLEN-1:0]        quo_fix_s;
    logic [XLEN-1:0]        rem_fix_s;
    logic [XLEN:0]          sum_s;
    logic [2*XLEN-1:0]      acc_nxt_s;
    logic [2*XLEN-1:0]      prod_fix_s;
`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0]      fprod_s;
    logic [2*XLEN-1:0]      fprod_fix_s;
`endif

    // Operand signedness, magnitudes and the accept strobe.
    always_comb begin
        s1_s     = op1_signed(funct3_i) & op1_i[XLEN-1];
        s2_s     = op2_signed(funct3_i) & op2_i[XLEN-1];
        mag1_s   = s1_s ? ({XLEN{1'b0}} - op1_i) : op1_i;
        mag2_s   = s2_s ? ({XLEN{1'b0}} - op2_i) : op2_i;
        accept_s = (state_r == ST_IDLE) && valid_i && !flush_i;
    end

    // Results that skip the iteration entirely (divide corner cases, fast multiply).
    always_comb begin
        fast_s     = 1'b0;
        fast_res_s = {XLEN{1'b0}};
`ifdef MULDIV_FAST_MUL_EN
        fprod_s     = {{XLEN{1'b0}}, mag1_s} * {{XLEN{1'b0}}, mag2_s};
        fprod_fix_s = (s1_s ^ s2_s) ? ({(2*XLEN){1'b0}} - fprod_s) : fprod_s;
`endif
        if (funct3_i[2]) begin
            if (op2_i == {XLEN{1'b0}}) begin
                fast_s     = 1'b1;
                fast_res_s = funct3_i[1] ? op1_i : ALL_ONES;
            end else if (((funct3_i == DIV_F3) || (funct3_i == REM_F3)) &&
                         (op1_i == INT_MIN) && (op2_i == ALL_ONES)) begin
                fast_s     = 1'b1;
                fast_res_s = funct3_i[1] ? {XLEN{1'b0}} : op1_i;
            end else begin
                fast_s     = 1'b0;
                fast_res_s = {XLEN{1'b0}};
            end
        end else begin
`ifdef MULDIV_FAST_MUL_EN
            fast_s     = 1'b1;
            fast_res_s = (funct3_i == MUL_F3) ? fprod_fix_s[XLEN-1:0]
                                              : fprod_fix_s[2*XLEN-1:XLEN];
`else
            fast_s     = 1'b0;
            fast_res_s = {XLEN{1'b0}};
`endif
        end
    end

    // Shift-add step plus sign fix-up and final selection of the iterated result.
    always_comb begin
        sum_s      = {1'b0, acc_r[2*XLEN-1:XLEN]} +
                     {1'b0, (acc_r[0] ? mcand_r : {XLEN{1'b0}})};
        acc_nxt_s  = {sum_s, acc_r[XLEN-1:1]};
        prod_fix_s = neg_r ? ({(2*XLEN){1'b0}} - acc_nxt_s) : acc_nxt_s;
        quo_fix_s  = neg_r ? ({XLEN{1'b0}} - quo_nxt_s) : quo_nxt_s;
        rem_fix_s  = rem_neg_r ? ({XLEN{1'b0}} - rem_nxt_s) : rem_nxt_s;
        case (f3_r)
            MUL_F3:                       calc_res_s = prod_fix_s[XLEN-1:0];
            MULH_F3, MULHSU_F3, MULHU_F3: calc_res_s = prod_fix_s[2*XLEN-1:XLEN];
            DIV_F3, DIVU_F3:              calc_res_s = quo_fix_s;
            REM_F3, REMU_F3:              calc_res_s = rem_fix_s;
            default:                      calc_res_s = {XLEN{1'b0}};
        endcase
    end

    muldiv_divcore #(
        .XLEN (XLEN)
    ) u_divcore (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .start_i    (accept_s),
        .step_i     (state_r == ST_CALC),
        .dividend_i (mag1_s),
        .divisor_i  (mag2_s),
        .last_o     (div_last_s),
        .quo_next_o (quo_nxt_s),
        .rem_next_o (rem_nxt_s)
    );

    // Operation context captured at accept, multiply accumulator and result register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            f3_r      <= 3'b000;
            waddr_r   <= '0;
            neg_r     <= 1'b0;
            rem_neg_r <= 1'b0;
            mcand_r   <= '0;
            acc_r     <= '0;
            result_r  <= '0;
        end else if (accept_s) begin
            f3_r      <= funct3_i;
            waddr_r   <= reg_waddr_i;
            neg_r     <= s1_s ^ s2_s;
            rem_neg_r <= s1_s;
            mcand_r   <= mag1_s;
            acc_r     <= {{XLEN{1'b0}}, mag2_s};
            if (fast_s) begin
                result_r <= fast_res_s;
            end
        end else if ((state_r == ST_CALC) && !flush_i) begin
            acc_r <= acc_nxt_s;
            if (div_last_s) begin
                result_r <= calc_res_s;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next state; flush outranks accept and result hand-off.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (flush_i) begin
                    state_nxt_s = ST_IDLE;
                end else if (valid_i) begin
                    state_nxt_s = fast_s ? ST_DONE : ST_CALC;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (flush_i) begin
                    state_nxt_s = ST_IDLE;
                end else if (div_last_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_CALC;
                end
            end
            ST_DONE: begin
                if (flush_i || out_ready_i) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM outputs decoded from the state register only.
    always_comb begin
        ready_o = 1'b0;
        busy_o  = 1'b0;
        valid_o = 1'b0;
        case (state_r)
            ST_IDLE: ready_o = !rst_i;
            ST_CALC: busy_o  = 1'b1;
            ST_DONE: begin
                busy_o  = 1'b1;
                valid_o = 1'b1;
            end
            default: begin
                ready_o = 1'b0;
                busy_o  = 1'b0;
                valid_o = 1'b0;
            end
        endcase
        reg_we_o = valid_o && (waddr_r != '0);
    end

    assign result_o    = result_r;
    assign reg_waddr_o = waddr_r;

endmodule

// File: doc/exe_muldiv_seq.md
# exe_muldiv_seq

Parametrised, multi-cycle RV M-extension execute unit (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) for an XLEN-bit core. It sits beside the single-cycle execute stage. On an M-type instruction the execute stage hands the operands over with a valid/ready handshake and stalls until the result returns. Multiply uses radix-2 shift-add and divide uses restoring division, each one bit per cycle. Divide-by-zero and signed overflow take a one-cycle fast path.

## Interface
- XLEN, 32: operand/result width; 32 or 64.
- RADDR_WIDTH, 5: destination register address width.
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset; asynchronous, active-high.
- valid_i  in  1  request present.
- ready_o  out  1  unit idle, request accepted when valid_i && ready_o.
- funct3_i  in  3  M-op select, standard RV encoding (000 MUL … 111 REMU).
- op1_i  in  XLEN  rs1 value / dividend / multiplicand.
- op2_i  in  XLEN  rs2 value / divisor / multiplier.
- reg_waddr_i  in  RADDR_WIDTH  destination register.
- flush_i  in  1  kill the in-flight operation (branch/trap).
- valid_o  out  1  result valid.
- out_ready_i  in  1  consumer takes the result.
- result_o  out  XLEN  result.
- reg_waddr_o  out  RADDR_WIDTH  destination, captured at accept.
- reg_we_o  out  1  valid_o && (reg_waddr_o != 0).
- busy_o  out  1  state != IDLE; drives the pipeline stall.

## Operation
- States: IDLE, CALC, DONE.
- IDLE: ready_o=1.
  - On accept, latch funct3, reg_waddr and absolute operand magnitudes, plus the result sign.
  - Signedness: MULH/DIV/REM treat both operands as signed. MULHSU treats op1 as signed and op2 as unsigned. The remaining ops are unsigned.
  - Fast path, IDLE→DONE with the result loaded directly:
    - Divisor zero: DIV/DIVU = all ones; REM/REMU = op1_i.
    - DIV with op1 = 2^(XLEN-1) and op2 = -1: quotient = op1_i.
    - REM with the same operands: 0.
  - Otherwise IDLE→CALC with counter = XLEN-1.
- CALC: one iteration per cycle; counter decrements; at counter 0 → DONE.
  - Multiply: 2·XLEN-bit product accumulator.
  - Divide: XLEN+1-bit partial remainder.
- Entering DONE from CALC: apply sign fix-up by two's-complement negation of the magnitude result, then select the result:
  - MUL: low XLEN bits.
  - MULH/MULHSU/MULHU: high XLEN bits.
  - Quotient: negated iff operand signs differ.
  - Remainder: takes the dividend's sign.
- DONE: valid_o=1, result_o stable until out_ready_i; DONE && out_ready_i → IDLE. No accept in the same cycle, because ready_o=0 outside IDLE.
- flush_i: from any state, next state IDLE, valid_o=0 next cycle, no write.
  - flush_i outranks accept and out_ready_i in the same cycle.
- rd = x0: the operation runs to completion with reg_we_o=0.
- All arithmetic is unsigned on magnitudes; widths never truncate before the final select.

## Timing
- Reset: state IDLE; valid_o=0, busy_o=0, reg_we_o=0, result_o=0, reg_waddr_o=0. ready_o=0 while rst_i is high, 1 after release.
- Reset mid-operation aborts the operation immediately (asynchronous); no result is produced.
- Iterative latency: accept in cycle 0, CALC in cycles 1..XLEN, valid_o in cycle XLEN+1.
- Fast-path latency: valid_o in cycle 1.
- Throughput: one op per (latency + 1) cycles minimum; one IDLE cycle follows each completion.
- Outputs are registered; there is no combinational path from inputs to valid_o/result_o.

## Configuration
- MULDIV_FAST_MUL_EN defined: all multiplies take the fast path, one registered XLEN×XLEN product with latency 1. Divide is unchanged.
- Undefined: multiplies iterate, latency XLEN+1.

## Structure
- Shared package holds:
  - funct3 constants MUL_F3…REMU_F3 and the state enum.
  - MEM/ZERO constants already used by the execute stage.
- Natural sub-module: muldiv_divcore, which holds the restoring-divide datapath with its counter and remainder registers. The top keeps the FSM, sign handling and multiply.

## Test plan
- XLEN=32, MUL 7 × -3 → result_o 0xFFFFFFEB, valid_o in cycle 33, reg_we_o=1.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULHSU -1 × 2 → 0xFFFFFFFF.
- DIV -7 / 2 → 0xFFFFFFFD. REM -7 % 2 → 0xFFFFFFFF. REMU 7 % 2 → 1.
- Fast paths, all with valid_o in cycle 1:
  - DIVU 5 / 0 → 0xFFFFFFFF.
  - REM 5 % 0 → 5.
  - DIV 0x80000000 / -1 → 0x80000000.
  - REM with the same operands → 0.
- flush_i in cycle 10 of a DIV → busy_o=0 next cycle, no valid_o; a new MUL is accepted afterwards and gives the correct result.
- Backpressure: hold out_ready_i=0 for 5 cycles in DONE → result_o stable and ready_o=0 throughout. Assert rst_i during CALC → all outputs at reset values immediately.
